// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Package     : hazard_pkg
// Description : Shared types and constants for the pipeline hazard unit.
//               fwd_t      - ALU operand source select
//               hz_state_t - registered hazard state encoding
//               CNT_W      - performance counter width
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_t;

    typedef enum logic [1:0] {
        RUN     = 2'b00,
        LDSTALL = 2'b01,
        PCDRAIN = 2'b10,
        BRFLUSH = 2'b11
    } hz_state_t;

    // Memory-stage result is the younger one, so it wins when both match.
    function automatic fwd_t fwd_sel(
        input logic [3:0] ra_e,
        input logic [3:0] wa3_m,
        input logic       reg_write_m,
        input logic [3:0] wa3_w,
        input logic       reg_write_w
    );
        fwd_t sel;
        sel = FWD_RF;
        if (reg_write_m && (ra_e == wa3_m)) begin
            sel = FWD_M;
        end else if (reg_write_w && (ra_e == wa3_w)) begin
            sel = FWD_W;
        end
        return sel;
    endfunction

endpackage
`default_nettype wire

// File: rtl/hazard_if.sv
`default_nettype none
// ============================================================================
// Interface   : hazard_if
// Description : Bundle between the pipeline datapath/controller and the
//               hazard unit.
//   master : drives register addresses, write/load flags, PC-hazard flags and
//            CntClr; receives forwarding selects, stall/flush controls,
//            HzState and the performance counters.
//   slave  : the hazard unit side (directions reversed).
// Revision    : 1.0 - initial release
// ============================================================================
interface hazard_if;
    import hazard_pkg::*;

    logic [3:0]       RA1D;
    logic [3:0]       RA2D;
    logic [3:0]       RA1E;
    logic [3:0]       RA2E;
    logic [3:0]       WA3E;
    logic [3:0]       WA3M;
    logic [3:0]       WA3W;
    logic             RegWriteM;
    logic             RegWriteW;
    logic             MemtoRegE;
    logic             PCWrPendingF;
    logic             PCSrcW;
    logic             BranchTakenE;
    logic             CntClr;

    fwd_t             ForwardAE;
    fwd_t             ForwardBE;
    logic             StallF;
    logic             StallD;
    logic             FlushD;
    logic             FlushE;
    hz_state_t        HzState;
    logic [CNT_W-1:0] StallCycles;
    logic [CNT_W-1:0] FlushCycles;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        output RegWriteM, RegWriteW, MemtoRegE,
        output PCWrPendingF, PCSrcW, BranchTakenE, CntClr,
        input  ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        input  HzState, StallCycles, FlushCycles
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
        input  RegWriteM, RegWriteW, MemtoRegE,
        input  PCWrPendingF, PCSrcW, BranchTakenE, CntClr,
        output ForwardAE, ForwardBE, StallF, StallD, FlushD, FlushE,
        output HzState, StallCycles, FlushCycles
    );

endinterface
`default_nettype wire

// File: rtl/sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Saturating up-counter with synchronous clear.
//   clk   - rising-edge clock
//   reset - synchronous, active-low; loads zero
//   clr   - synchronous clear; any increment in the same cycle is dropped
//   inc   - count enable
//   count - current value, holds at all-ones
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             clr,
    input  wire logic             inc,
    output logic      [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_d;
    logic [CNT_W-1:0] count_q;

    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (inc && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule
`default_nettype wire

// File: rtl/hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : hazard_unit
// Description : Pipeline hazard unit. Produces operand forwarding selects,
//               load-use stall and branch/PC flush controls combinationally,
//               tracks a registered hazard state, and counts stall/flush
//               cycles in two saturating counters.
//   clk   - rising-edge clock
//   reset - synchronous, active-low
//   hz    - hazard_if.slave: register addresses, write/load and PC-hazard
//           flags, CntClr in; ForwardAE/BE, StallF/D, FlushD/E, HzState,
//           StallCycles, FlushCycles out
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_unit
    import hazard_pkg::*;
(
    input  wire logic clk,
    input  wire logic reset,
    hazard_if.slave   hz
);

    logic      ldrstall;
    hz_state_t hz_state_d;
    hz_state_t hz_state_q;

    assign ldrstall = hz.MemtoRegE &&
                      ((hz.RA1D == hz.WA3E) || (hz.RA2D == hz.WA3E));

    // While in reset the pipeline is held flushing so only bubbles advance.
    always_comb begin
        hz.ForwardAE = FWD_RF;
        hz.ForwardBE = FWD_RF;
        hz.StallF    = 1'b0;
        hz.StallD    = 1'b0;
        hz.FlushD    = 1'b1;
        hz.FlushE    = 1'b1;
        if (reset) begin
            hz.ForwardAE = fwd_sel(hz.RA1E, hz.WA3M, hz.RegWriteM,
                                   hz.WA3W, hz.RegWriteW);
            hz.ForwardBE = fwd_sel(hz.RA2E, hz.WA3M, hz.RegWriteM,
                                   hz.WA3W, hz.RegWriteW);
            hz.StallD    = ldrstall;
            hz.StallF    = ldrstall || hz.PCWrPendingF;
            hz.FlushD    = hz.PCWrPendingF || hz.PCSrcW || hz.BranchTakenE;
            hz.FlushE    = ldrstall || hz.BranchTakenE;
        end
    end

    // Next state depends only on the current hazard condition, not on the
    // present state, so every state has the same transitions.
    always_comb begin
        hz_state_d = RUN;
        if (hz.BranchTakenE) begin
            hz_state_d = BRFLUSH;
        end else if (hz.PCWrPendingF || hz.PCSrcW) begin
            hz_state_d = PCDRAIN;
        end else if (ldrstall) begin
            hz_state_d = LDSTALL;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hz_state_q <= RUN;
        end else begin
            hz_state_q <= hz_state_d;
        end
    end

    assign hz.HzState = hz_state_q;

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (hz.CntClr),
        .inc   (hz.StallF),
        .count (hz.StallCycles)
    );

    sat_counter #(
        .CNT_W (CNT_W)
    ) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .clr   (hz.CntClr),
        .inc   (hz.FlushE),
        .count (hz.FlushCycles)
    );

endmodule
`default_nettype wire

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL use one clock; reset is synchronous and active-low.
REQ-002 SHALL have port clk, input, 1 bit: rising-edge clock.
REQ-003 SHALL have port reset, input, 1 bit: synchronous, active-low (0 = reset).
REQ-004 SHALL have ports RA1D and RA2D, inputs, 4 bits each: Decode-stage source registers.
REQ-005 SHALL have ports RA1E, RA2E and WA3E, inputs, 4 bits each: Execute-stage source and destination registers.
REQ-006 SHALL have ports WA3M and WA3W, inputs, 4 bits each: Memory- and Writeback-stage destination registers.
REQ-007 SHALL have ports RegWriteM, RegWriteW and MemtoRegE, inputs, 1 bit each: controller pipeline write/load flags.
REQ-008 SHALL have ports PCWrPendingF, PCSrcW and BranchTakenE, inputs, 1 bit each: controller PC-hazard signals.
REQ-009 SHALL have port CntClr, input, 1 bit: synchronous clear of both performance counters.
REQ-010 SHALL have ports ForwardAE and ForwardBE, outputs, 2 bits each: ALU operand source select.
REQ-011 SHALL have ports StallF, StallD, FlushD and FlushE, outputs, 1 bit each: pipeline register control; FlushE drives the controller's FlushE input.
REQ-012 SHALL have port HzState, output, 2 bits: registered hazard state.
REQ-013 SHALL have ports StallCycles and FlushCycles, outputs, 16 bits each: saturating performance counters.

Function
REQ-014 ForwardAE SHALL be 10 when RA1E==WA3M and RegWriteM=1; else 01 when RA1E==WA3W and RegWriteW=1; else 00. M-stage priority applies when both match.
REQ-015 ForwardBE SHALL follow the same rule using RA2E.
REQ-016 ldrstall SHALL be MemtoRegE AND ((RA1D==WA3E) OR (RA2D==WA3E)).
REQ-017 StallD SHALL equal ldrstall; StallF SHALL equal ldrstall OR PCWrPendingF.
REQ-018 FlushD SHALL equal PCWrPendingF OR PCSrcW OR BranchTakenE.
REQ-019 FlushE SHALL equal ldrstall OR BranchTakenE.
REQ-020 REQ-014 to REQ-019 SHALL be combinational, with zero-cycle latency.
REQ-021 HzState SHALL be a registered FSM with states RUN=00, LDSTALL=01, PCDRAIN=10, BRFLUSH=11.
REQ-022 Next state SHALL be chosen by first match: BranchTakenE -> BRFLUSH; else PCWrPendingF or PCSrcW -> PCDRAIN; else ldrstall -> LDSTALL; else RUN. This applies from any state.
REQ-023 HzState SHALL reflect the cycle-N condition at cycle N+1 (one-cycle latency).
REQ-024 StallCycles SHALL increment at each clock edge where StallF=1.
REQ-025 FlushCycles SHALL increment at each clock edge where FlushE=1.
REQ-026 Each counter SHALL saturate at 16'hFFFF with no wrap.
REQ-027 Counter priority SHALL be: reset, then CntClr (clear to 0, increment discarded in that cycle), then increment.
REQ-028 Simultaneous ldrstall and BranchTakenE SHALL assert StallF, StallD, FlushD and FlushE together; the FSM goes to BRFLUSH.

Reset
REQ-029 While reset=0 at a clock edge, HzState SHALL load RUN and both counters SHALL load 0.
REQ-030 While reset=0, the combinational outputs SHALL be forced to ForwardAE=ForwardBE=00, StallF=StallD=0, FlushD=FlushE=1, so the pipeline drains bubbles.
REQ-031 Reset asserted mid-stall SHALL override the stall in the same cycle.

Structure
REQ-032 Package hazard_pkg SHALL hold:
- fwd_t enum: FWD_RF=00, FWD_W=01, FWD_M=10
- hz_state_t enum
- CNT_W=16
REQ-033 Sub-module sat_counter (parameter CNT_W; inputs clk, reset, clr, inc; output count) SHALL be instantiated twice.

Verification
REQ-034 Forwarding: RA1E=3, WA3M=3, RegWriteM=1, WA3W=3, RegWriteW=1 -> ForwardAE=10; then RegWriteM=0 -> ForwardAE=01.
REQ-035 Load-use: MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1, FlushD=0; HzState=01 next cycle; StallCycles +1.
REQ-036 Branch plus load-use together: BranchTakenE=1 with a load-use condition -> all four stall/flush outputs =1; HzState=11 next cycle; FlushCycles +1.
REQ-037 PC write: PCWrPendingF=1 for 3 cycles, then PCSrcW=1 for 1 cycle -> StallF=1 for 3 cycles, FlushD=1 for 4 cycles; HzState=10 throughout, RUN after.
REQ-038 Saturation: hold StallF=1 for 65,540 cycles -> StallCycles=FFFF; CntClr=1 -> 0000 next edge.
REQ-039 Reset mid-operation: reset=0 during a load-use stall -> StallF=0, FlushE=1, HzState=00 and counters=0 after the edge.
